niosqs_multi_timer: RTL
=======================

// Module: niosqs_multi_timer
// PURPOSE
//  Parametrised multi-channel interval timer on one Avalon-MM slave, next generation of the single
//  32-bit timer. NUM_CH independent down-counters, each with prescaler, one-shot/continuous mode,
//  snapshot and own interrupt. Sits on the Nios II data bus; irq feeds the CPU IRQ input.
// PARAMETERS
//  NUM_CH        4      number of timer channels (1..16)
//  CNT_W         32     counter/period width (8..DATA_W)
//  DATA_W        32     Avalon data width
//  PRESCALE_W    8      prescaler divisor field width (<= DATA_W-8)
//  RESET_PERIOD  99999  reset value of every period register and counter
//  (localparam ADDR_W = $clog2(NUM_CH)+2)
// PORTS
//  clk        in   1        system clock
//  reset      in   1        synchronous, active-high reset
//  address    in   ADDR_W   word address {channel, reg[1:0]}
//  chipselect in   1        slave select
//  write_n    in   1        active-low write strobe
//  writedata  in   DATA_W   write data
//  readdata   out  DATA_W   registered read data
//  irq_vec    out  NUM_CH   per-channel interrupt (TO & ITO)
//  irq        out  1        OR of irq_vec
// BEHAVIOUR
//  Clocking: one clock; reset is synchronous and active-high.
//  Reset: counters, PERIOD = RESET_PERIOD; CONTROL, STATUS, SNAP, prescalers, readdata = 0; irq = 0.
//  Per-channel register map (reg):
//   0 STATUS  r: {RUN,TO} in bits[1:0]. Any write clears TO.
//   1 CONTROL r/w: b0 ITO, b1 CONT, b2 START, b3 STOP, b[8+:PRESCALE_W] PSC. START/STOP are
//             self-clearing strobes, read back as 0.
//   2 PERIOD  r/w: low CNT_W bits stored; read zero-extended.
//   3 SNAP    write (any data) copies live counter; read returns snapshot zero-extended.
//  Read: readdata valid on the cycle after chipselect (read latency 1). It updates every cycle from
//   address, regardless of chipselect.
//  Unmapped channel index (NUM_CH not a power of 2): reads 0; writes are ignored.
//  Tick: the prescaler counts PSC..0. A tick is produced at 0, followed by a reload of PSC, so a tick
//   occurs every PSC+1 cycles. PSC = 0 gives a tick every cycle. The prescaler resets to PSC on START
//   and on every CONTROL write.
//  Counter: when RUN is set and a tick occurs, it decrements. On a tick at 0:
//   - the counter reloads PERIOD,
//   - TO sets,
//   - RUN clears if CONT = 0.
//  Period 0 with CONT = 1 gives a timeout on every tick.
//  PERIOD write: the counter is loaded with the new value on the next cycle and RUN clears. Software
//   must START again.
//  START and STOP in the same write: START wins.
//  START while running: the counter is not reloaded and continues.
//  STATUS-clear in the same cycle as a timeout event: the set wins, so TO stays 1 and no event is lost.
//  SNAP write in the same cycle as a decrement: captures the pre-decrement value.
//  irq_vec[i] = TO[i] & ITO[i], combinational from registers, with no extra latency. irq = |irq_vec.
//  Reset asserted mid-count: all state returns to reset values on that edge, with no pending irq.
// STRUCTURE
//  Package niosqs_timer_pkg holds:
//   - register offsets STATUS/CONTROL/PERIOD/SNAP,
//   - control bit indices (ITO, CONT, START, STOP, PSC_LSB),
//   - status bit indices.
//  Sub-module niosqs_timer_channel (one per channel, generate loop) holds prescaler, counter, RUN/TO,
//   PERIOD, CONTROL and SNAP. It takes decoded wr strobes per reg and returns its 4 read words.
//  Top holds the address decode, the read mux, the readdata register and the irq OR.
// TESTING
//  1. Reset with no writes: readdata = 0 and irq = 0. Reading ch0 PERIOD returns 99999 one cycle later.
//  2. ch1: PERIOD = 4, CONTROL = 0x7 (ITO|CONT|START), PSC = 0. TO/irq_vec[1] rise 5 cycles after
//     START, then every 5 cycles. A STATUS write clears irq for 4 cycles.
//  3. ch2: PERIOD = 2, PSC = 3, CONTROL = START|ITO, one-shot. TO rises after 12 cycles, RUN = 0 and
//     the counter holds 2.
//  4. Simultaneous: STATUS clear aligned with the timeout cycle leaves TO = 1. CONTROL = START|STOP
//     leaves RUN = 1.
//  5. SNAP write mid-count with PERIOD = 100 after 10 ticks: SNAP reads 90 (pre-decrement capture).
//     A PERIOD write mid-count clears RUN and the counter equals the new period.
//  6. NUM_CH = 3 build: address of ch3 reads 0, and writes to it change no channel.

Source files
------------

// File: rtl/niosqs_timer_pkg.sv
// Shared register map, control/status bit positions and write-strobe bundle
// for the multi-channel interval timer.
package niosqs_timer_pkg;

    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_CONTROL = 2'd1;
    localparam logic [1:0] REG_PERIOD  = 2'd2;
    localparam logic [1:0] REG_SNAP    = 2'd3;

    localparam int unsigned CTRL_ITO     = 0;
    localparam int unsigned CTRL_CONT    = 1;
    localparam int unsigned CTRL_START   = 2;
    localparam int unsigned CTRL_STOP    = 3;
    localparam int unsigned CTRL_PSC_LSB = 8;

    localparam int unsigned STAT_TO  = 0;
    localparam int unsigned STAT_RUN = 1;

    // One-hot decoded write strobes for a single channel
    typedef struct packed {
        logic status;
        logic control;
        logic period;
        logic snap;
    } reg_wr_t;

endpackage

// File: rtl/niosqs_timer_channel.sv
// One timer channel: prescaler, down-counter, RUN/TO flags, PERIOD, CONTROL and
// SNAP registers. Returns its four read words and its interrupt.
module niosqs_timer_channel
    import niosqs_timer_pkg::*;
#(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned PRESCALE_W   = 8,
    parameter int unsigned RESET_PERIOD = 99999
) (
    input  logic                   clk,
    input  logic                   reset,
    input  reg_wr_t                wr_i,
    input  logic [DATA_W-1:0]      wdata_i,
    output logic [3:0][DATA_W-1:0] rdata_o,
    output logic                   irq_c_o
);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      period_q, period_d;
    logic [CNT_W-1:0]      snap_q, snap_d;
    logic [PRESCALE_W-1:0] psc_q, psc_d;
    logic [PRESCALE_W-1:0] psc_cnt_q, psc_cnt_d;
    logic                  ito_q, ito_d;
    logic                  cont_q, cont_d;
    logic                  run_q, run_d;
    logic                  to_q, to_d;
    logic                  tick;
    logic                  timeout;
    logic                  unused_wdata;

    assign unused_wdata = ^wdata_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= CNT_W'(RESET_PERIOD);
            period_q  <= CNT_W'(RESET_PERIOD);
            snap_q    <= '0;
            psc_q     <= '0;
            psc_cnt_q <= '0;
            ito_q     <= 1'b0;
            cont_q    <= 1'b0;
            run_q     <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            snap_q    <= snap_d;
            psc_q     <= psc_d;
            psc_cnt_q <= psc_cnt_d;
            ito_q     <= ito_d;
            cont_q    <= cont_d;
            run_q     <= run_d;
            to_q      <= to_d;
        end
    end

    // Later assignments take priority: register writes override tick effects,
    // except that a timeout always beats a STATUS clear.
    always_comb begin
        cnt_d     = cnt_q;
        period_d  = period_q;
        snap_d    = snap_q;
        psc_d     = psc_q;
        psc_cnt_d = psc_cnt_q;
        ito_d     = ito_q;
        cont_d    = cont_q;
        run_d     = run_q;
        to_d      = to_q;

        tick    = run_q && (psc_cnt_q == '0);
        timeout = tick && (cnt_q == '0);

        if (run_q) begin
            psc_cnt_d = (psc_cnt_q == '0) ? psc_q : psc_cnt_q - PRESCALE_W'(1);
        end
        if (tick) begin
            if (timeout) begin
                cnt_d = period_q;
                if (!cont_q) begin
                    run_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        if (wr_i.status) begin
            to_d = 1'b0;
        end
        if (timeout) begin
            to_d = 1'b1;
        end

        if (wr_i.snap) begin
            snap_d = cnt_q;
        end

        if (wr_i.control) begin
            ito_d     = wdata_i[CTRL_ITO];
            cont_d    = wdata_i[CTRL_CONT];
            psc_d     = wdata_i[CTRL_PSC_LSB +: PRESCALE_W];
            psc_cnt_d = wdata_i[CTRL_PSC_LSB +: PRESCALE_W];
            if (wdata_i[CTRL_START]) begin
                run_d = 1'b1;
            end else if (wdata_i[CTRL_STOP]) begin
                run_d = 1'b0;
            end
        end

        if (wr_i.period) begin
            period_d = wdata_i[CNT_W-1:0];
            cnt_d    = wdata_i[CNT_W-1:0];
            run_d    = 1'b0;
        end
    end

    always_comb begin
        rdata_o                                      = '0;
        rdata_o[REG_STATUS][STAT_TO]                 = to_q;
        rdata_o[REG_STATUS][STAT_RUN]                = run_q;
        rdata_o[REG_CONTROL][CTRL_ITO]               = ito_q;
        rdata_o[REG_CONTROL][CTRL_CONT]              = cont_q;
        rdata_o[REG_CONTROL][CTRL_PSC_LSB +: PRESCALE_W] = psc_q;
        rdata_o[REG_PERIOD]                          = DATA_W'(period_q);
        rdata_o[REG_SNAP]                            = DATA_W'(snap_q);
    end

    assign irq_c_o = to_q & ito_q;

endmodule

// File: rtl/niosqs_multi_timer.sv
// Multi-channel interval timer on one Avalon-MM slave: address decode, read mux,
// registered read data and interrupt aggregation.
module niosqs_multi_timer
    import niosqs_timer_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned PRESCALE_W   = 8,
    parameter int unsigned RESET_PERIOD = 99999,
    localparam int unsigned ADDR_W      = $clog2(NUM_CH) + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic [NUM_CH-1:0] irq_vec,
    output logic              irq
);

    localparam int unsigned CH_W    = (ADDR_W > 2) ? ADDR_W - 2 : 1;
    localparam int unsigned NCH_POW = 1 << CH_W;

    logic [CH_W-1:0]          ch_idx;
    logic [1:0]               reg_idx;
    logic                     wr_en;
    logic [3:0][DATA_W-1:0]   rd_all [NCH_POW];
    logic [DATA_W-1:0]        readdata_q, readdata_d;

    assign reg_idx = address[1:0];
    assign wr_en   = chipselect & ~write_n;

    if (ADDR_W > 2) begin : g_ch_idx
        assign ch_idx = address[ADDR_W-1:2];
    end else begin : g_ch_idx_single
        assign ch_idx = '0;
    end

    // Unmapped channel slots read as zero and never receive write strobes
    for (genvar i = 0; i < NCH_POW; i++) begin : g_ch
        if (i < NUM_CH) begin : g_live
            reg_wr_t wr;
            logic    ch_sel;

            assign ch_sel     = wr_en && (ch_idx == CH_W'(i));
            assign wr.status  = ch_sel && (reg_idx == REG_STATUS);
            assign wr.control = ch_sel && (reg_idx == REG_CONTROL);
            assign wr.period  = ch_sel && (reg_idx == REG_PERIOD);
            assign wr.snap    = ch_sel && (reg_idx == REG_SNAP);

            niosqs_timer_channel #(
                .CNT_W        (CNT_W),
                .DATA_W       (DATA_W),
                .PRESCALE_W   (PRESCALE_W),
                .RESET_PERIOD (RESET_PERIOD)
            ) u_channel (
                .clk     (clk),
                .reset   (reset),
                .wr_i    (wr),
                .wdata_i (writedata),
                .rdata_o (rd_all[i]),
                .irq_c_o (irq_vec[i])
            );
        end else begin : g_empty
            assign rd_all[i] = '0;
        end
    end

    assign readdata_d = rd_all[ch_idx][reg_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_q <= '0;
        end else begin
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |irq_vec;

endmodule
